// File: rtl/wave_capture_mc.sv
// wave_capture_mc: N-channel trigger-aligned circular waveform capture with trigger-relative read port
module wave_capture_mc #(
   parameter int          CH_NUM   = 2,
   parameter int          DATA_W   = 8,
   parameter int          ADDR_W   = 9,
   parameter logic [23:0] AUTO_TMO = 24'd5000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [CH_NUM*DATA_W-1:0] din,
   input  logic                     din_valid,
   input  logic [1:0]               trig_ch,
   input  logic [DATA_W-1:0]        trig_level,
   input  logic [1:0]               trig_edge,
   input  logic [1:0]               trig_mode,
   input  logic [ADDR_W-1:0]        pretrig,
   input  logic                     wave_run,
   input  logic                     arm,
   input  logic [ADDR_W-1:0]        rd_addr,
   input  logic                     rd_en,
   output logic [CH_NUM*DATA_W-1:0] rd_data,
   input  logic                     rd_release,
   output logic                     cap_done,
   output logic                     auto_trig,
   output logic                     busy
);
   localparam int W     = CH_NUM * DATA_W;
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

   state_t              state;
   logic [W-1:0]        mem [DEPTH];
   logic [W-1:0]        prev;
   logic [ADDR_W-1:0]   wr_ptr, trig_ptr, cfg_pre, phys;
   logic [ADDR_W:0]     cnt, cnt_nx, post_len;
   logic [23:0]         tmo;
   logic [1:0]          cfg_ch, cfg_edge, cfg_mode, sel;
   logic [DATA_W-1:0]   cfg_level, s, p;
   logic                rise, fall, edge_hit, tmo_hit, wr_en, rearm, start;

   // channel select falls back to channel 0 for out-of-range requests
   assign sel      = (int'(cfg_ch) < CH_NUM) ? cfg_ch : 2'd0;
   assign s        = din[int'(sel)*DATA_W +: DATA_W];
   assign p        = prev[int'(sel)*DATA_W +: DATA_W];
   assign rise     = (p < cfg_level) && (s >= cfg_level);
   assign fall     = (p >= cfg_level) && (s < cfg_level);
   assign edge_hit = din_valid && (cfg_edge[1] ? (rise || fall) : cfg_edge[0] ? fall : rise);
   assign tmo_hit  = din_valid && (cfg_mode == 2'b00) && (tmo == AUTO_TMO - 24'd1);
   assign wr_en    = din_valid && (state == PRE || state == WAIT_TRIG || state == POST);
   assign rearm    = wave_run && (cfg_mode[1] ? arm : rd_release);
   assign start    = (state == IDLE && wave_run) || (state == DONE && rearm);
   assign cnt_nx   = cnt + 1'b1;
   assign post_len = (ADDR_W+1)'(DEPTH) - {1'b0, cfg_pre};
   assign phys     = trig_ptr - cfg_pre + rd_addr;

   // sample buffer write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // registered trigger-relative read, holds when not strobed
   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else if (rd_en) rd_data <= mem[phys];
   end

   // capture configuration frozen at the start of each acquisition
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_ch    <= '0;
         cfg_edge  <= '0;
         cfg_mode  <= '0;
         cfg_level <= '0;
         cfg_pre   <= '0;
      end else if (start) begin
         cfg_ch    <= trig_ch;
         cfg_edge  <= trig_edge;
         cfg_mode  <= trig_mode;
         cfg_level <= trig_level;
         cfg_pre   <= pretrig;
      end
   end

   // acquisition state machine with write pointer, counters and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         trig_ptr  <= '0;
         cnt       <= '0;
         tmo       <= '0;
         prev      <= '0;
         cap_done  <= 1'b0;
         auto_trig <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (din_valid && state != IDLE) prev <= din;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (start) begin
                  state <= PRE;
                  busy  <= 1'b1;
               end
            end
            PRE: begin
               if (cfg_pre == '0) begin
                  state <= WAIT_TRIG;
                  tmo   <= '0;
               end else if (din_valid) begin
                  cnt <= cnt_nx;
                  if (cnt_nx == {1'b0, cfg_pre}) begin
                     state <= WAIT_TRIG;
                     tmo   <= '0;
                  end
               end
            end
            WAIT_TRIG: begin
               if (edge_hit || tmo_hit) begin
                  trig_ptr  <= wr_ptr;
                  auto_trig <= !edge_hit;
                  cnt       <= (ADDR_W+1)'(1);
                  if (post_len == (ADDR_W+1)'(1)) begin
                     state    <= DONE;
                     cap_done <= 1'b1;
                     busy     <= 1'b0;
                  end else begin
                     state <= POST;
                  end
               end else if (cfg_mode == 2'b00 && tmo != AUTO_TMO - 24'd1) begin
                  tmo <= tmo + 24'd1;
               end
            end
            POST: begin
               if (din_valid) begin
                  cnt <= cnt_nx;
                  if (cnt_nx == post_len) begin
                     state    <= DONE;
                     cap_done <= 1'b1;
                     busy     <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  state    <= PRE;
                  cap_done <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
